// File: rtl/nvdla_csb_pkg.sv
// CSB request/response field layout, response packet ids, the interrupt
// service FSM state type and the 63-bit request packer.
package nvdla_csb_pkg;

  localparam int CSB_REQ_W     = 63;
  localparam int CSB_RESP_W    = 34;
  localparam int CSB_ADDR_W    = 22;
  localparam int CSB_DATA_W    = 32;

  localparam int REQ_ADDR_LSB  = 0;
  localparam int REQ_WDAT_LSB  = 22;
  localparam int REQ_WRITE_BIT = 54;
  localparam int REQ_NPOST_BIT = 55;
  localparam int REQ_PRIV_BIT  = 56;
  localparam int REQ_WRBE_LSB  = 57;
  localparam int REQ_LEVEL_LSB = 61;

  localparam int RESP_ID_BIT   = 33;
  localparam int RESP_ERR_BIT  = 32;

  localparam logic RESP_PKT_RD = 1'b0;
  localparam logic RESP_PKT_WR = 1'b1;

  typedef enum logic [2:0] {
    SVC_IDLE    = 3'd0,
    SVC_RD_REQ  = 3'd1,
    SVC_RD_WAIT = 3'd2,
    SVC_WR_REQ  = 3'd3,
    SVC_WR_WAIT = 3'd4,
    SVC_DONE    = 3'd5
  } svc_state_e;

  // Every request is a full-word, privileged, level-0 access.
  function automatic logic [CSB_REQ_W-1:0] csb_req_pack(
    input logic                  write,
    input logic                  nposted,
    input logic [CSB_DATA_W-1:0] wdat,
    input logic [CSB_ADDR_W-1:0] addr
  );
    logic [CSB_REQ_W-1:0] pd;
    pd = '0;
    pd[REQ_ADDR_LSB +: CSB_ADDR_W] = addr;
    pd[REQ_WDAT_LSB +: CSB_DATA_W] = wdat;
    pd[REQ_WRITE_BIT]              = write;
    pd[REQ_NPOST_BIT]              = nposted;
    pd[REQ_PRIV_BIT]               = 1'b1;
    pd[REQ_WRBE_LSB +: 4]          = 4'hF;
    pd[REQ_LEVEL_LSB +: 2]         = 2'b00;
    return pd;
  endfunction

endpackage

// File: rtl/nvdla_glb_intr_svc.sv
// GLB done-interrupt service initiator: reads the interrupt status over CSB,
// writes the value back to clear it and reports the serviced bits as an event.
// Optional response timeout: define NVDLA_INTR_SVC_TMO_EN.
//
//  state    | meaning
//  ---------+-------------------------------------------------
//  IDLE     | waiting for svc_en & core_intr
//  RD_REQ   | presenting status read request
//  RD_WAIT  | waiting for read response
//  WR_REQ   | presenting write-1-to-clear of the read value
//  WR_WAIT  | waiting for write response
//  DONE     | one-cycle event pulse, error flag cleared
module nvdla_glb_intr_svc
  import nvdla_csb_pkg::*;
#(
  parameter logic [21:0] STATUS_ADDR = 22'h000003,
  parameter int          TMO_CYCLES  = 1024,
  parameter int          TMO_W       = 11
) (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rst,
  input  logic        svc_en,
  input  logic        core_intr,
  output logic        csb2glb_req_pvld,
  input  logic        csb2glb_req_prdy,
  output logic [62:0] csb2glb_req_pd,
  input  logic        glb2csb_resp_valid,
  input  logic [33:0] glb2csb_resp_pd,
  output logic        evt_valid,
  output logic [31:0] evt_status,
  output logic        evt_err,
  output logic        busy
);

  svc_state_e  r_state, w_state_nxt;
  logic [31:0] r_status, w_status_nxt;
  logic        r_err, w_err_nxt;
  logic [31:0] r_evt_status;
  logic        w_rd_resp, w_wr_resp, w_stray, w_resp_err, w_tmo_hit;
  logic [31:0] w_rdat;

  assign w_rdat     = glb2csb_resp_pd[31:0];
  assign w_resp_err = glb2csb_resp_pd[RESP_ERR_BIT];
  assign w_rd_resp  = glb2csb_resp_valid && (r_state == SVC_RD_WAIT)
                      && (glb2csb_resp_pd[RESP_ID_BIT] == RESP_PKT_RD);
  assign w_wr_resp  = glb2csb_resp_valid && (r_state == SVC_WR_WAIT)
                      && (glb2csb_resp_pd[RESP_ID_BIT] == RESP_PKT_WR);
  // Any response the FSM is not waiting for is dropped but remembered as an error.
  assign w_stray    = glb2csb_resp_valid && !w_rd_resp && !w_wr_resp;

`ifdef NVDLA_INTR_SVC_TMO_EN
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             w_in_wait;

  assign w_in_wait = (r_state == SVC_RD_WAIT) || (r_state == SVC_WR_WAIT);
  assign w_tmo_hit = w_in_wait && (r_tmo_cnt == TMO_W'(TMO_CYCLES - 1));

  // Wait-cycle counter: zero outside the wait states, saturating inside.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst || !w_in_wait)
      r_tmo_cnt <= '0;
    else if (r_tmo_cnt != TMO_W'(TMO_CYCLES - 1))
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end
`else
  logic [TMO_W-1:0] w_unused_tmo;
  assign w_unused_tmo = TMO_W'(TMO_CYCLES);
  assign w_tmo_hit    = 1'b0;
`endif

  // Next-state, request drive and status/error update.
  always_comb begin
    w_state_nxt      = r_state;
    w_status_nxt     = r_status;
    w_err_nxt        = r_err | w_stray;
    csb2glb_req_pvld = 1'b0;
    csb2glb_req_pd   = '0;
    unique case (r_state)
      SVC_IDLE: begin
        if (svc_en && core_intr) begin
          w_state_nxt  = SVC_RD_REQ;
          w_status_nxt = '0;
        end
      end
      SVC_RD_REQ: begin
        csb2glb_req_pvld = 1'b1;
        csb2glb_req_pd   = csb_req_pack(1'b0, 1'b0, 32'h0, STATUS_ADDR);
        if (csb2glb_req_prdy) w_state_nxt = SVC_RD_WAIT;
      end
      SVC_RD_WAIT: begin
        if (w_rd_resp) begin
          w_status_nxt = w_rdat;
          w_err_nxt    = r_err | w_resp_err;
          w_state_nxt  = (w_resp_err || (w_rdat == 32'h0)) ? SVC_DONE : SVC_WR_REQ;
        end else if (w_tmo_hit) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = SVC_DONE;
        end
      end
      SVC_WR_REQ: begin
        csb2glb_req_pvld = 1'b1;
        csb2glb_req_pd   = csb_req_pack(1'b1, 1'b1, r_status, STATUS_ADDR);
        if (csb2glb_req_prdy) w_state_nxt = SVC_WR_WAIT;
      end
      SVC_WR_WAIT: begin
        if (w_wr_resp) begin
          w_err_nxt   = r_err | w_resp_err;
          w_state_nxt = SVC_DONE;
        end else if (w_tmo_hit) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = SVC_DONE;
        end
      end
      SVC_DONE: begin
        w_err_nxt   = w_stray;
        w_state_nxt = SVC_IDLE;
      end
      default: w_state_nxt = SVC_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_state      <= SVC_IDLE;
      r_status     <= '0;
      r_err        <= 1'b0;
      r_evt_status <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_status <= w_status_nxt;
      r_err    <= w_err_nxt;
      if (r_state == SVC_DONE) r_evt_status <= r_status;
    end
  end

  assign evt_valid  = (r_state == SVC_DONE);
  assign evt_status = evt_valid ? r_status : r_evt_status;
  assign evt_err    = evt_valid && r_err;
  assign busy       = (r_state != SVC_IDLE);

endmodule

// File: tb/tb_nvdla_glb_intr_svc.sv
// Directed bench for the GLB interrupt service initiator; the CSB target is
// modelled by hand-driven handshakes and responses.
module tb_nvdla_glb_intr_svc;

`ifdef NVDLA_INTR_SVC_TMO_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif

  logic        clk = 1'b0;
  logic        rst, svc_en, core_intr, req_prdy, resp_valid;
  logic [33:0] resp_pd;
  logic        req_pvld, evt_valid, evt_err, busy;
  logic [62:0] req_pd;
  logic [31:0] evt_status;

  int n_checks = 0;
  int n_err    = 0;

  nvdla_glb_intr_svc #(.STATUS_ADDR(22'h000003), .TMO_CYCLES(TMO), .TMO_W(11)) dut (
    .nvdla_core_clk    (clk),
    .nvdla_core_rst    (rst),
    .svc_en            (svc_en),
    .core_intr         (core_intr),
    .csb2glb_req_pvld  (req_pvld),
    .csb2glb_req_prdy  (req_prdy),
    .csb2glb_req_pd    (req_pd),
    .glb2csb_resp_valid(resp_valid),
    .glb2csb_resp_pd   (resp_pd),
    .evt_valid         (evt_valid),
    .evt_status        (evt_status),
    .evt_err           (evt_err),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdat;
    logic        rerr;
    logic        werr;
    logic        exp_wr;
    logic [31:0] exp_status;
    logic        exp_err;
  } vec_t;

  vec_t vecs[5];

  // Request layout: {level, wrbe, srcpriv, nposted, write, wdat, addr}.
  function automatic logic [62:0] exp_pd(input logic wr, input logic [31:0] wdat);
    return {2'b00, 4'hF, 1'b1, wr, wr, wdat, 22'h000003};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic wait_pvld(input string nm);
    int i = 0;
    while (!req_pvld && i < 20) begin
      tick;
      i++;
    end
    chk({nm, " pvld_seen"}, 64'(req_pvld), 64'd1);
  endtask

  task automatic wait_evt(input string nm);
    int i = 0;
    while (!evt_valid && i < 20) begin
      tick;
      i++;
    end
    chk({nm, " evt_seen"}, 64'(evt_valid), 64'd1);
  endtask

  task automatic handshake;
    req_prdy = 1'b1;
    tick;
    req_prdy = 1'b0;
  endtask

  task automatic respond(input logic id, input logic err, input logic [31:0] d);
    resp_valid = 1'b1;
    resp_pd    = {id, err, d};
    tick;
    resp_valid = 1'b0;
    resp_pd    = '0;
  endtask

  task automatic run_seq(input vec_t v, input string nm);
    wait_pvld({nm, " rd"});
    chk({nm, " rd_pd"}, 64'(req_pd), 64'(exp_pd(1'b0, 32'h0)));
    handshake;
    chk({nm, " rd_pvld_drop"}, 64'(req_pvld), 64'd0);
    tick;
    respond(1'b0, v.rerr, v.rdat);
    if (v.exp_wr) begin
      wait_pvld({nm, " wr"});
      chk({nm, " wr_pd"}, 64'(req_pd), 64'(exp_pd(1'b1, v.rdat)));
      handshake;
      tick;
      respond(1'b1, v.werr, 32'h0);
    end else begin
      chk({nm, " no_write"}, 64'(req_pvld), 64'd0);
    end
    wait_evt(nm);
    chk({nm, " evt_status"}, 64'(evt_status), 64'(v.exp_status));
    chk({nm, " evt_err"}, 64'(evt_err), 64'(v.exp_err));
    tick;
    chk({nm, " evt_one_cycle"}, 64'(evt_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    vec_t late;
    vecs[0] = '{32'h0000_0011, 1'b0, 1'b0, 1'b1, 32'h0000_0011, 1'b0};
    vecs[1] = '{32'hDEAD_0001, 1'b1, 1'b0, 1'b0, 32'hDEAD_0001, 1'b1};
    vecs[2] = '{32'h8000_0004, 1'b0, 1'b1, 1'b1, 32'h8000_0004, 1'b1};
    vecs[3] = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0};
    vecs[4] = '{32'h0000_0005, 1'b0, 1'b0, 1'b1, 32'h0000_0005, 1'b0};

    rst = 1'b1; svc_en = 1'b0; core_intr = 1'b0; req_prdy = 1'b0;
    resp_valid = 1'b0; resp_pd = '0;
    tick; tick;
    chk("rst pvld", 64'(req_pvld), 64'd0);
    chk("rst pd", 64'(req_pd), 64'd0);
    chk("rst evt_valid", 64'(evt_valid), 64'd0);
    chk("rst evt_status", 64'(evt_status), 64'd0);
    chk("rst evt_err", 64'(evt_err), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    rst = 1'b0;
    tick;

    // Disabled service ignores the interrupt.
    core_intr = 1'b1;
    repeat (4) tick;
    chk("svc_dis busy", 64'(busy), 64'd0);

    // One-cycle decision latency, then request stalled for 5 cycles.
    svc_en = 1'b1;
    tick;
    chk("decide latency pvld", 64'(req_pvld), 64'd1);
    for (int i = 0; i < 5; i++) begin
      chk("stall pvld", 64'(req_pvld), 64'd1);
      chk("stall pd", 64'(req_pd), 64'(exp_pd(1'b0, 32'h0)));
      tick;
    end

    // Table: normal, read error, write error, zero status, re-trigger.
    for (int i = 0; i < 5; i++) begin
      core_intr = 1'b1;
      run_seq(vecs[i], $sformatf("vec%0d", i));
      if (i != 3) begin
        core_intr = 1'b0;
        tick; tick;
        chk($sformatf("vec%0d idle", i), 64'(busy), 64'd0);
      end
    end

    // svc_en drop mid-sequence: sequence completes, then IDLE holds.
    core_intr = 1'b1;
    wait_pvld("en_drop");
    svc_en = 1'b0;
    run_seq(vecs[0], "en_drop");
    repeat (4) tick;
    chk("en_drop idle_hold", 64'(busy), 64'd0);
    svc_en = 1'b1;
    core_intr = 1'b0;
    tick;

    // Reset in WR_WAIT, late write response lands in IDLE.
    core_intr = 1'b1;
    wait_pvld("rst_mid rd");
    handshake;
    tick;
    respond(1'b0, 1'b0, 32'h0000_0011);
    wait_pvld("rst_mid wr");
    handshake;
    core_intr = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst_mid pvld", 64'(req_pvld), 64'd0);
    chk("rst_mid pd", 64'(req_pd), 64'd0);
    chk("rst_mid evt_valid", 64'(evt_valid), 64'd0);
    chk("rst_mid evt_status", 64'(evt_status), 64'd0);
    chk("rst_mid evt_err", 64'(evt_err), 64'd0);
    chk("rst_mid busy", 64'(busy), 64'd0);
    respond(1'b1, 1'b0, 32'h0);
    tick;
    late = '{32'h0000_0022, 1'b0, 1'b0, 1'b1, 32'h0000_0022, 1'b1};
    core_intr = 1'b1;
    run_seq(late, "late_resp");
    core_intr = 1'b0;
    tick; tick;

`ifdef NVDLA_INTR_SVC_TMO_EN
    // Read timeout: event after 16 wait cycles.
    begin
      int k = 0;
      core_intr = 1'b1;
      wait_pvld("tmo");
      handshake;
      core_intr = 1'b0;
      while (!evt_valid && k < 40) begin
        tick;
        k++;
      end
      chk("tmo wait_cycles", 64'(k), 64'd16);
      chk("tmo evt_err", 64'(evt_err), 64'd1);
      chk("tmo evt_status", 64'(evt_status), 64'd0);
      tick;
    end
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
